// File: rtl/etapa_busqueda.sv
// Instruction-fetch stage: owns the PC, selects the next PC (sequential, branch,
// jump, hold) and registers the fetched word plus PC+4 into the IF/ID latch.
module etapa_busqueda #(
    parameter int                 WIDTH    = 32,
    parameter logic [WIDTH-1:0]   RESET_PC = '0
) (
    input  logic               clkFase,
    input  logic               rstFase,
    input  logic               stall,
    input  logic               flush,
    input  logic               branch_taken,
    input  logic [WIDTH-1:0]   branch_target,
    input  logic               jump,
    input  logic [25:0]        jump_index,
    output logic [WIDTH-1:0]   imem_addr,
    input  logic [WIDTH-1:0]   imem_data,
    output logic [WIDTH-1:0]   if_id_instr,
    output logic [WIDTH-1:0]   if_id_pc4,
    output logic               if_id_valid,
    output logic [15:0]        fetch_count
);

    localparam logic [WIDTH-1:0] PC_STEP   = WIDTH'(4);
    localparam logic [15:0]      COUNT_MAX = 16'hFFFF;

    logic [WIDTH-1:0] pc_reg;
    logic [WIDTH-1:0] pc_next;
    logic [WIDTH-1:0] pc4;
    logic [WIDTH-1:0] jump_target;
    logic [WIDTH-1:0] branch_aligned;
    logic [WIDTH-1:0] if_id_instr_reg;
    logic [WIDTH-1:0] if_id_pc4_reg;
    logic             if_id_valid_reg;
    logic [15:0]      fetch_count_reg;
    logic             redirect;
    logic             bubble;
    logic             load;

    // Addition wraps naturally at 2^WIDTH, so the top word rolls over to zero.
    assign pc4            = pc_reg + PC_STEP;
    assign branch_aligned = {branch_target[WIDTH-1:2], 2'b00};
    // The jump sits in decode, so its region bits come from the IF/ID PC+4.
    assign jump_target    = {if_id_pc4_reg[WIDTH-1:28], jump_index, 2'b00};

    assign redirect = branch_taken | jump;
    assign bubble   = flush | redirect;
    assign load     = ~bubble & ~stall;

    always_comb begin
        pc_next = pc4;
        if (branch_taken) begin
            pc_next = branch_aligned;
        end else if (jump) begin
            pc_next = jump_target;
        end else if (stall) begin
            pc_next = pc_reg;
        end
    end

    always_ff @(posedge clkFase or posedge rstFase) begin
        if (rstFase) begin
            pc_reg <= RESET_PC;
        end else begin
            pc_reg <= pc_next;
        end
    end

    always_ff @(posedge clkFase or posedge rstFase) begin
        if (rstFase) begin
            if_id_instr_reg <= '0;
            if_id_pc4_reg   <= '0;
            if_id_valid_reg <= 1'b0;
        end else if (bubble) begin
            if_id_instr_reg <= '0;
            if_id_pc4_reg   <= '0;
            if_id_valid_reg <= 1'b0;
        end else if (!stall) begin
            if_id_instr_reg <= imem_data;
            if_id_pc4_reg   <= pc4;
            if_id_valid_reg <= 1'b1;
        end
    end

    always_ff @(posedge clkFase or posedge rstFase) begin
        if (rstFase) begin
            fetch_count_reg <= '0;
        end else if (load && (fetch_count_reg != COUNT_MAX)) begin
            fetch_count_reg <= fetch_count_reg + 16'd1;
        end
    end

    assign imem_addr   = pc_reg;
    assign if_id_instr = if_id_instr_reg;
    assign if_id_pc4   = if_id_pc4_reg;
    assign if_id_valid = if_id_valid_reg;
    assign fetch_count = fetch_count_reg;

endmodule

// File: tb/tb_etapa_busqueda.sv
// Directed bench for etapa_busqueda: stimulus pushes expected post-edge state,
// a negedge monitor pops and compares it against the DUT outputs.
module tb_etapa_busqueda;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        logic [15:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, flush, branch_taken, jump;
    logic [31:0] branch_target;
    logic [25:0] jump_index;
    logic [31:0] imem_addr, imem_data, if_id_instr, if_id_pc4;
    logic        if_id_valid;
    logic [15:0] fetch_count;

    // Second instance exercising the wrap-around reset vector.
    logic        rst_w;
    logic [31:0] imem_addr_w, imem_data_w, if_id_instr_w, if_id_pc4_w;
    logic        if_id_valid_w;
    logic [15:0] fetch_count_w;

    int   compared   = 0;
    int   mismatched = 0;
    exp_t sb_q[$];
    int   step_no    = 0;

    always #5 clk = ~clk;

    assign imem_data   = 32'h2000_0000 + imem_addr;
    assign imem_data_w = 32'h2000_0000 + imem_addr_w;

    etapa_busqueda #(.WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
        .clkFase(clk), .rstFase(rst), .stall(stall), .flush(flush),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_index(jump_index),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4),
        .if_id_valid(if_id_valid), .fetch_count(fetch_count)
    );

    etapa_busqueda #(.WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clkFase(clk), .rstFase(rst_w), .stall(1'b0), .flush(1'b0),
        .branch_taken(1'b0), .branch_target(32'h0),
        .jump(1'b0), .jump_index(26'h0),
        .imem_addr(imem_addr_w), .imem_data(imem_data_w),
        .if_id_instr(if_id_instr_w), .if_id_pc4(if_id_pc4_w),
        .if_id_valid(if_id_valid_w), .fetch_count(fetch_count_w)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
        end
    endtask

    task automatic check_state(input string tag, input exp_t e);
        check({tag, " imem_addr"},   imem_addr,          e.pc);
        check({tag, " if_id_instr"}, if_id_instr,        e.instr);
        check({tag, " if_id_pc4"},   if_id_pc4,          e.pc4);
        check({tag, " if_id_valid"}, {31'b0, if_id_valid}, {31'b0, e.valid});
        check({tag, " fetch_count"}, {16'b0, fetch_count}, {16'b0, e.cnt});
    endtask

    // Monitor: the IF/ID latch presents a new output after every edge.
    always @(negedge clk) begin
        if (sb_q.size() != 0) begin
            exp_t e;
            e = sb_q.pop_front();
            step_no++;
            check_state($sformatf("step%0d", step_no), e);
            $display("step %0d: pc=%08h instr=%08h pc4=%08h valid=%0b cnt=%0d",
                     step_no, imem_addr, if_id_instr, if_id_pc4, if_id_valid, fetch_count);
        end
    end

    task automatic cyc(input logic st, input logic fl, input logic br, input logic [31:0] bt,
                       input logic jp, input logic [25:0] ji,
                       input logic [31:0] e_pc, input logic [31:0] e_instr,
                       input logic [31:0] e_pc4, input logic e_valid, input logic [15:0] e_cnt);
        exp_t e;
        stall = st; flush = fl; branch_taken = br; branch_target = bt;
        jump = jp; jump_index = ji;
        @(posedge clk);
        #1;
        e.pc = e_pc; e.instr = e_instr; e.pc4 = e_pc4; e.valid = e_valid; e.cnt = e_cnt;
        sb_q.push_back(e);
        stall = 0; flush = 0; branch_taken = 0; jump = 0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 10) begin
            @(negedge clk);
            #1;
            n++;
        end
        compared++;
        if (sb_q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: %0d entries left, required 0", sb_q.size());
        end
    endtask

    initial begin
        exp_t r;
        rst = 1; rst_w = 1;
        stall = 0; flush = 0; branch_taken = 0; jump = 0;
        branch_target = 0; jump_index = 0;
        #3;
        r = '0;
        check_state("reset", r);
        check("wrap reset pc", imem_addr_w, 32'hFFFF_FFFC);
        @(posedge clk); #2;
        rst = 0; rst_w = 0;

        // Sequential fetch, then a 3-edge stall at pc=0x8.
        cyc(0,0,0,0,0,0, 32'h4,  32'h2000_0000, 32'h4,  1, 1);
        check("wrap pc",          imem_addr_w,   32'h0000_0000);
        check("wrap if_id_pc4",   if_id_pc4_w,   32'h0000_0000);
        check("wrap if_id_instr", if_id_instr_w, 32'h1FFF_FFFC);
        check("wrap valid",       {31'b0, if_id_valid_w}, 32'h1);
        cyc(0,0,0,0,0,0, 32'h8,  32'h2000_0004, 32'h8,  1, 2);
        cyc(1,0,0,0,0,0, 32'h8,  32'h2000_0004, 32'h8,  1, 2);
        cyc(1,0,0,0,0,0, 32'h8,  32'h2000_0004, 32'h8,  1, 2);
        cyc(1,0,0,0,0,0, 32'h8,  32'h2000_0004, 32'h8,  1, 2);
        cyc(0,0,0,0,0,0, 32'hC,  32'h2000_0008, 32'hC,  1, 3);
        // Branch at pc=0xC to 0x43 (low bits dropped).
        cyc(0,0,1,32'h43,0,0, 32'h40, 32'h0, 32'h0, 0, 3);
        cyc(0,0,0,0,0,0, 32'h44, 32'h2000_0040, 32'h44, 1, 4);
        // Move into the 0x1000_xxxx region, then jump relative to it.
        cyc(0,0,1,32'h1000_0004,0,0, 32'h1000_0004, 32'h0, 32'h0, 0, 4);
        cyc(0,0,0,0,0,0, 32'h1000_0008, 32'h3000_0004, 32'h1000_0008, 1, 5);
        cyc(0,0,0,0,1,26'h10, 32'h1000_0040, 32'h0, 32'h0, 0, 5);
        cyc(0,0,0,0,0,0, 32'h1000_0044, 32'h3000_0040, 32'h1000_0044, 1, 6);
        // Branch and jump together: branch wins.
        cyc(0,0,1,32'h80,1,26'h10, 32'h80, 32'h0, 32'h0, 0, 6);
        cyc(0,0,0,0,0,0, 32'h84, 32'h2000_0080, 32'h84, 1, 7);
        // Stall with branch: redirect overrides the hold.
        cyc(1,0,1,32'h200,0,0, 32'h200, 32'h0, 32'h0, 0, 7);
        cyc(0,0,0,0,0,0, 32'h204, 32'h2000_0200, 32'h204, 1, 8);
        // Plain flush advances pc; flush+stall holds pc.
        cyc(0,1,0,0,0,0, 32'h208, 32'h0, 32'h0, 0, 8);
        cyc(0,0,0,0,0,0, 32'h20C, 32'h2000_0208, 32'h20C, 1, 9);
        cyc(1,1,0,0,0,0, 32'h20C, 32'h0, 32'h0, 0, 9);
        cyc(0,0,0,0,0,0, 32'h210, 32'h2000_020C, 32'h210, 1, 10);
        drain();

        // Asynchronous reset between edges with a pending branch.
        #2;
        branch_taken = 1; branch_target = 32'h300;
        rst = 1;
        #1;
        r = '0;
        check_state("async_reset", r);
        @(posedge clk); #1;
        check_state("reset_held", r);
        branch_taken = 0; branch_target = 0;
        #2;
        rst = 0;
        cyc(0,0,0,0,0,0, 32'h4, 32'h2000_0000, 32'h4, 1, 1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation exceeded 20000 time units");
        $fatal(1, "timeout");
    end

endmodule
